// File: rtl/popcount21_char.sv
// popcount21_char: exhaustive error-characterisation engine for an external
// N_IN-input approximate popcount candidate. Sweeps every input vector,
// compares the candidate count with the exact count through a two-stage
// pipeline and accumulates the MAE numerator, the worst-case error and the
// number of erroneous vectors.
// Optional feature: define POPCOUNT_CHAR_BIAS_EN to add the signed err_bias
// accumulator of (approx - exact).
module popcount21_char #(
  parameter int N_IN  = 21,
  parameter int W_OUT = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [N_IN-1:0]           pc_in,
  input  logic [W_OUT-1:0]          pc_out,
  output logic                      busy,
  output logic                      done,
  output logic [N_IN+W_OUT-1:0]     err_sum,
  output logic [W_OUT-1:0]          wce,
  output logic [N_IN:0]             err_cnt
`ifdef POPCOUNT_CHAR_BIAS_EN
  ,
  output logic signed [N_IN+W_OUT:0] err_bias
`endif
);

  localparam int CW = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Exact population count, zero-extended to the candidate width.
  function automatic logic [W_OUT-1:0] exact_count(input logic [N_IN-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) begin
      c = c + CW'(v[i]);
    end
    return W_OUT'(c);
  endfunction

  state_t                  state_q, state_d;
  logic [N_IN-1:0]         vec_q, vec_d;
  logic                    drain_q, drain_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clear_s;
  logic                    s1_valid_q, s1_valid_d;
  logic [W_OUT-1:0]        s1_approx_q, s1_approx_d;
  logic [W_OUT-1:0]        s1_exact_q, s1_exact_d;
  logic [W_OUT-1:0]        diff_abs_s;
  logic [N_IN+W_OUT-1:0]   err_sum_q, err_sum_d;
  logic [W_OUT-1:0]        wce_q, wce_d;
  logic [N_IN:0]           err_cnt_q, err_cnt_d;
`ifdef POPCOUNT_CHAR_BIAS_EN
  logic signed [W_OUT:0]       diff_signed_s;
  logic signed [N_IN+W_OUT:0]  bias_q, bias_d;
`endif

  // Sequencer: vector sweep, two-cycle drain and start handling.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drain_d = drain_q;
    clear_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (vec_q == {N_IN{1'b1}}) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Pipeline: S1 captures the candidate and exact counts, S2 accumulates.
  always_comb begin
    s1_valid_d  = (state_q == S_RUN) && !clear_s;
    s1_approx_d = pc_out;
    s1_exact_d  = exact_count(vec_q);
    if (s1_approx_q >= s1_exact_q) begin
      diff_abs_s = s1_approx_q - s1_exact_q;
    end else begin
      diff_abs_s = s1_exact_q - s1_approx_q;
    end
    err_sum_d = err_sum_q;
    wce_d     = wce_q;
    err_cnt_d = err_cnt_q;
`ifdef POPCOUNT_CHAR_BIAS_EN
    diff_signed_s = $signed({1'b0, s1_approx_q}) - $signed({1'b0, s1_exact_q});
    bias_d        = bias_q;
`endif
    if (clear_s) begin
      err_sum_d = '0;
      wce_d     = '0;
      err_cnt_d = '0;
`ifdef POPCOUNT_CHAR_BIAS_EN
      bias_d    = '0;
`endif
    end else if (s1_valid_q) begin
      err_sum_d = err_sum_q + (N_IN+W_OUT)'(diff_abs_s);
      wce_d     = (diff_abs_s > wce_q) ? diff_abs_s : wce_q;
      err_cnt_d = err_cnt_q + (N_IN+1)'(diff_abs_s != '0);
`ifdef POPCOUNT_CHAR_BIAS_EN
      bias_d    = bias_q + {{N_IN{diff_signed_s[W_OUT]}}, diff_signed_s};
`endif
    end else begin
      err_sum_d = err_sum_q;
    end
  end

  // State, sweep and accumulator registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_approx_q <= '0;
      s1_exact_q  <= '0;
      err_sum_q   <= '0;
      wce_q       <= '0;
      err_cnt_q   <= '0;
`ifdef POPCOUNT_CHAR_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_approx_q <= s1_approx_d;
      s1_exact_q  <= s1_exact_d;
      err_sum_q   <= err_sum_d;
      wce_q       <= wce_d;
      err_cnt_q   <= err_cnt_d;
`ifdef POPCOUNT_CHAR_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end

  // The sweep register doubles as the candidate drive: 0 in IDLE, all-ones
  // after the sweep.
  assign pc_in   = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_sum = err_sum_q;
  assign wce     = wce_q;
  assign err_cnt = err_cnt_q;
`ifdef POPCOUNT_CHAR_BIAS_EN
  assign err_bias = bias_q;
`endif

endmodule

// File: tb/tb_popcount21_char.sv
// Bench for popcount21_char at N_IN=4, W_OUT=3: fixed candidate table,
// randomized look-up-table candidates against a whole-sweep reference model,
// start re-pulses, restart from DONE and an asynchronous mid-run reset.
// Bias checks are active when POPCOUNT_CHAR_BIAS_EN is defined.
module tb_popcount21_char;
  localparam int N = 4;
  localparam int W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [N-1:0]       pc_in;
  logic [W-1:0]       pc_out;
  logic               busy;
  logic               done;
  logic [N+W-1:0]     err_sum;
  logic [W-1:0]       wce;
  logic [N:0]         err_cnt;
`ifdef POPCOUNT_CHAR_BIAS_EN
  logic signed [N+W:0] err_bias;
`endif

  int          total = 0;
  int          bad   = 0;
  int          mode  = 0;
  logic [W-1:0] lut [16];

  typedef struct {
    int mode;
    int rep;
    int e_sum;
    int e_wce;
    int e_cnt;
    int e_bias;
  } vec_t;
  vec_t tbl [4];

  popcount21_char #(.N_IN(N), .W_OUT(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pc_in   (pc_in),
    .pc_out  (pc_out),
    .busy    (busy),
    .done    (done),
    .err_sum (err_sum),
    .wce     (wce),
    .err_cnt (err_cnt)
`ifdef POPCOUNT_CHAR_BIAS_EN
    ,
    .err_bias(err_bias)
`endif
  );

  always #5 clk = ~clk;

  // Candidate behaviour for each bench mode.
  function automatic int cand_val(input int m, input int v);
    int e;
    e = $countones(v);
    case (m)
      0: return e;
      1: return 0;
      2: return (v == 15) ? 5 : e;
      3: return int'(lut[v]);
      default: return e;
    endcase
  endfunction

  always_comb pc_out = W'(cand_val(mode, int'(pc_in)));

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: walk all vectors once and accumulate the error metrics.
  task automatic ref_model(input int m, output int s, output int w, output int c, output int b);
    s = 0; w = 0; c = 0; b = 0;
    for (int v = 0; v < (1 << N); v++) begin
      int a, e, d;
      a = cand_val(m, v);
      e = $countones(v);
      d = (a > e) ? a - e : e - a;
      s += d;
      if (d > w) w = d;
      if (d != 0) c++;
      b += a - e;
    end
  endtask

  task automatic run_char(input int rep, input int es, input int ew, input int ec, input int eb);
    int cyc;
    int seq_err;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", longint'(busy), 1);
    check("pc_in_first", longint'(pc_in), 0);
    check("sum_cleared", longint'(err_sum), 0);
    check("cnt_cleared", longint'(err_cnt), 0);
    check("wce_cleared", longint'(wce), 0);
    check("done_cleared", longint'(done), 0);
    cyc = 0;
    seq_err = 0;
    while (!done && cyc < 100) begin
      start = (rep != 0 && (cyc == 5 || cyc == 16 || cyc == 17)) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (int'(pc_in) != ((cyc < 16) ? cyc : 15)) seq_err++;
    end
    start = 1'b0;
    check("done_cycle", cyc, 18);
    check("pc_in_sequence_errors", seq_err, 0);
    check("busy_at_done", longint'(busy), 0);
    check("pc_in_at_done", longint'(pc_in), 15);
    check("err_sum", longint'(err_sum), es);
    check("wce", longint'(wce), ew);
    check("err_cnt", longint'(err_cnt), ec);
`ifdef POPCOUNT_CHAR_BIAS_EN
    check("err_bias", longint'(err_bias), eb);
`endif
  endtask

  initial begin
    int s, w, c, b;
    int found;
    tbl[0] = '{mode: 0, rep: 1, e_sum: 0,  e_wce: 0, e_cnt: 0,  e_bias: 0};
    tbl[1] = '{mode: 1, rep: 0, e_sum: 32, e_wce: 4, e_cnt: 15, e_bias: -32};
    tbl[2] = '{mode: 2, rep: 0, e_sum: 1,  e_wce: 1, e_cnt: 1,  e_bias: 1};
    tbl[3] = '{mode: 1, rep: 1, e_sum: 32, e_wce: 4, e_cnt: 15, e_bias: -32};
    for (int i = 0; i < 16; i++) lut[i] = '0;

    rst_n = 1'b0;
    start = 1'b0;
    #12;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_pc_in", longint'(pc_in), 0);
    check("rst_err_sum", longint'(err_sum), 0);
    check("rst_wce", longint'(wce), 0);
    check("rst_err_cnt", longint'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", longint'(busy), 0);

    // Table-driven runs (entry 3 restarts straight from DONE).
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_char(tbl[i].rep, tbl[i].e_sum, tbl[i].e_wce, tbl[i].e_cnt, tbl[i].e_bias);
    end
    repeat (3) @(negedge clk);
    check("done_holds", longint'(done), 1);
    check("result_holds", longint'(err_sum), 32);

    // Randomized look-up-table candidates against the reference model.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) lut[i] = W'($urandom_range(0, 7));
      mode = 3;
      ref_model(3, s, w, c, b);
      run_char(r & 1, s, w, c, b);
    end

    // Asynchronous reset in the middle of a sweep.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (pc_in == 4'd7) found = 1;
    end
    check("reached_vec7", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_pc_in", longint'(pc_in), 0);
    check("midrst_err_sum", longint'(err_sum), 0);
    check("midrst_err_cnt", longint'(err_cnt), 0);
    check("midrst_wce", longint'(wce), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", longint'(busy), 0);
    run_char(0, 32, 4, 15, -32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
